io_output_bank: RTL and testbench



---
 rtl/io_pkg.sv | 37 +++
 rtl/io_output_bank_if.sv | 18 +
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 rtl/io_output_bank.sv | 115 +++++++++++
 tb/tb_io_output_bank.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : io_pkg
// Description : Shared definitions for the I/O output-port bank. Contains the
//               converter state encoding, the default base address, the STATUS
//               field layout and the register-offset helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package io_pkg;

  // States of the sequential binary-to-BCD converter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  // Byte address of port 0.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0080;

  // Field layout of the read-only STATUS register.
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_CNT_LSB  = 8;
  localparam int STATUS_CNT_W    = 8;

  // The MODE register immediately follows the last PORT register.
  function automatic int unsigned mode_word_offset(input int unsigned num_ports);
    return num_ports;
  endfunction

  // The STATUS register immediately follows MODE.
  function automatic int unsigned status_word_offset(input int unsigned num_ports);
    return num_ports + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_output_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : io_output_bank_if
// Description : CPU I/O-space bus between the CPU data path and the output
//               port bank: byte address, write data, write strobe and the
//               combinational readback data.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_output_bank_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        write_io_enable;
  logic [31:0] rdata;

  modport master (output addr, output datain, output write_io_enable, input rdata);
  modport slave  (input addr, input datain, input write_io_enable, output rdata);
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter. The raw
//               switch input is synchronised with two flops; every time the
//               synchronised value differs from the last converted value a new
//               conversion runs (IN_W shift cycles plus one commit cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import io_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int NUM_DIGITS = 3
) (
  input  wire logic                    io_clk,
  input  wire logic                    clrn,
  input  wire logic [IN_W-1:0]         i_in_port,
  output logic      [4*NUM_DIGITS-1:0] o_digits,
  output logic      [7:0]              o_conv_count,
  output logic                         o_busy
);

  localparam int ACC_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

  logic [IN_W-1:0]       r_sync1;
  logic [IN_W-1:0]       r_sync2;
  logic [IN_W-1:0]       r_last;
  logic [IN_W-1:0]       r_shift;
  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [ACC_W-1:0]      r_digits;
  logic [7:0]            r_conv_count;
  bcd_state_e            r_state;
  bcd_state_e            w_next_state;
  logic [ACC_W-1:0]      w_acc_adj;
  logic [ACC_W+IN_W-1:0] w_cat;

  // Two-flop synchroniser for the asynchronous switch input.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_in_port;
      r_sync2 <= r_sync1;
    end
  end

  // Converter state register.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: a new value starts a run, the last shift moves to commit.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (r_sync2 != r_last) w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_cnt == LAST_SHIFT) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Add-3 correction on every nibble of 5 or more, then shift one bit in.
  always_comb begin
    w_acc_adj = r_acc;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
    w_cat = {w_acc_adj, r_shift} << 1;
  end

  // Conversion datapath: capture, shift and commit of the finished digits.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      r_last       <= '0;
      r_shift      <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_digits     <= '0;
      r_conv_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_sync2 != r_last) begin
            r_shift <= r_sync2;
            r_last  <= r_sync2;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          r_acc   <= w_cat[IN_W +: ACC_W];
          r_shift <= w_cat[IN_W-1:0];
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          r_digits     <= r_acc;
          r_conv_count <= r_conv_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_digits     = r_digits;
  assign o_conv_count = r_conv_count;
  assign o_busy       = (r_state == ST_SHIFT) || (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: rtl/io_output_bank.sv
`default_nettype none
// ============================================================================
// Module      : io_output_bank
// Description : Memory-mapped output-port bank. Holds NUM_PORTS CPU-writable
//               port registers and a MODE register that routes BCD digits of
//               the switch input onto individual ports. STATUS exposes the
//               converter busy flag and its conversion counter.
// Revision    : 1.0 - initial release
// ============================================================================
module io_output_bank
  import io_pkg::*;
#(
  parameter int          NUM_PORTS  = 6,
  parameter int          PORT_W     = 4,
  parameter int          IN_W       = 8,
  parameter int          NUM_DIGITS = 3,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  wire logic                        io_clk,
  input  wire logic                        clrn,
  io_output_bank_if.slave                  bus,
  input  wire logic [IN_W-1:0]             in_port,
  output logic      [NUM_PORTS*PORT_W-1:0] out_port,
  output logic                             bcd_busy
);

  localparam int OFF_W = ADDR_W - 2;
  localparam logic [OFF_W-1:0] BASE_WORD  = BASE_ADDR[ADDR_W-1:2];
  localparam logic [OFF_W-1:0] MODE_OFF   = OFF_W'(mode_word_offset(NUM_PORTS));
  localparam logic [OFF_W-1:0] STATUS_OFF = OFF_W'(status_word_offset(NUM_PORTS));

  logic [PORT_W-1:0]       r_port [NUM_PORTS];
  logic [NUM_PORTS-1:0]    r_mode;
  logic [OFF_W-1:0]        w_word;
  logic [OFF_W-1:0]        w_off;
  logic                    w_in_range;
  logic                    w_port_hit;
  logic                    w_mode_hit;
  logic                    w_status_hit;
  logic [31:0]             w_rdata;
  logic [4*NUM_DIGITS-1:0] w_digits;
  logic [7:0]              w_conv_count;
  logic                    w_busy;
  logic                    w_unused;

  bin2bcd_seq #(
    .IN_W       (IN_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .io_clk       (io_clk),
    .clrn         (clrn),
    .i_in_port    (in_port),
    .o_digits     (w_digits),
    .o_conv_count (w_conv_count),
    .o_busy       (w_busy)
  );

  // Word decode: only addr[ADDR_W-1:2] takes part; everything below BASE misses.
  always_comb begin
    w_word       = bus.addr[ADDR_W-1:2];
    w_in_range   = (w_word >= BASE_WORD);
    w_off        = w_word - BASE_WORD;
    w_port_hit   = w_in_range && (w_off < OFF_W'(NUM_PORTS));
    w_mode_hit   = w_in_range && (w_off == MODE_OFF);
    w_status_hit = w_in_range && (w_off == STATUS_OFF);
  end

  // CPU-writable register file; STATUS and unmapped writes fall through.
  always_ff @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NUM_PORTS; i++) r_port[i] <= '0;
      r_mode <= '0;
    end else if (bus.write_io_enable) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_port_hit && (w_off == OFF_W'(i))) r_port[i] <= bus.datain[PORT_W-1:0];
      end
      if (w_mode_hit) r_mode <= bus.datain[NUM_PORTS-1:0];
    end
  end

  // Combinational readback; PORT reads return the shadow value regardless of MODE.
  always_comb begin
    w_rdata = '0;
    if (w_port_hit) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_off == OFF_W'(i)) w_rdata = 32'(r_port[i]);
      end
    end else if (w_mode_hit) begin
      w_rdata = 32'(r_mode);
    end else if (w_status_hit) begin
      w_rdata[STATUS_BUSY_BIT]                = w_busy;
      w_rdata[STATUS_CNT_LSB +: STATUS_CNT_W] = w_conv_count;
    end
  end

  assign bus.rdata = w_rdata;
  assign bcd_busy  = w_busy;

  // Per-port source select; ports beyond the converter's digit count read 0 in BCD mode.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [3:0] w_digit;
    if (gi < NUM_DIGITS) begin : g_bcd
      assign w_digit = w_digits[4*gi +: 4];
    end else begin : g_zero
      assign w_digit = 4'd0;
    end
    assign out_port[gi*PORT_W +: PORT_W] = r_mode[gi] ? PORT_W'(w_digit) : r_port[gi];
  end

  // Bus bits outside the decoded/written range are intentionally ignored.
  assign w_unused = &{1'b0, bus.addr, bus.datain, w_digits};

endmodule
`default_nettype wire

// File: tb/tb_io_output_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_output_bank
// Description : Self-checking bench for io_output_bank against a behavioural
//               model (decimal arithmetic plus a cycle-count timing model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_output_bank;

  localparam int NP = 6;
  localparam int IW = 8;
  localparam int ND = 3;

  logic          io_clk = 1'b0;
  logic          clrn   = 1'b0;
  logic [IW-1:0] in_port = '0;
  logic [23:0]   out_port;
  logic          bcd_busy;
  int            n_checks = 0;
  int            n_errors = 0;

  io_output_bank_if bus();

  io_output_bank #(
    .NUM_PORTS(NP), .PORT_W(4), .IN_W(IW), .NUM_DIGITS(ND), .ADDR_W(8), .BASE_ADDR(32'h80)
  ) u_dut (
    .io_clk(io_clk), .clrn(clrn), .bus(bus), .in_port(in_port),
    .out_port(out_port), .bcd_busy(bcd_busy)
  );

  always #5 io_clk = ~io_clk;

  // ---------------- behavioural reference model ----------------
  logic [IW-1:0] m_s1, m_s2, m_last;
  int            m_val, m_rem, m_digits;
  logic [7:0]    m_count;
  logic [3:0]    m_port [NP];
  logic [NP-1:0] m_mode;

  function automatic int word_of(input logic [31:0] a);
    int b;
    b = int'(a[7:0]);
    if (b < 'h80) return -1;
    return (b - 'h80) / 4;
  endfunction

  function automatic logic [3:0] exp_port(input int i);
    int p;
    if (!m_mode[i]) return m_port[i];
    if (i >= ND) return 4'd0;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return 4'((m_digits / p) % 10);
  endfunction

  function automatic logic [23:0] exp_out();
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[i*4 +: 4] = exp_port(i);
    return v;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    int o;
    o = word_of(a);
    if (o < 0) return 32'd0;
    if (o < NP) return 32'(m_port[o]);
    if (o == NP) return 32'(m_mode);
    if (o == NP + 1) return {16'd0, m_count, 7'd0, (m_rem != 0)};
    return 32'd0;
  endfunction

  always @(posedge io_clk or negedge clrn) begin
    if (!clrn) begin
      m_s1 <= '0; m_s2 <= '0; m_last <= '0;
      m_val <= 0; m_rem <= 0; m_digits <= 0; m_count <= '0;
      for (int i = 0; i < NP; i++) m_port[i] <= '0;
      m_mode <= '0;
    end else begin
      m_s1 <= in_port;
      m_s2 <= m_s1;
      if (m_rem == 0) begin
        if (m_s2 != m_last) begin
          m_last <= m_s2; m_val <= int'(m_s2); m_rem <= IW + 1;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_digits <= m_val; m_count <= m_count + 8'd1;
        end
      end
      if (bus.write_io_enable) begin
        if (word_of(bus.addr) >= 0 && word_of(bus.addr) < NP) m_port[word_of(bus.addr)] <= bus.datain[3:0];
        else if (word_of(bus.addr) == NP) m_mode <= bus.datain[NP-1:0];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [3:0] port_of(input int i);
    return out_port[i*4 +: 4];
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus.addr = a; bus.datain = d; bus.write_io_enable = we;
    @(negedge io_clk);
    bus.write_io_enable = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_port = '0; bus.addr = '0; bus.datain = '0; bus.write_io_enable = 1'b0; clrn = 1'b0;
    repeat (3) @(negedge io_clk);
    n_checks++; if (out_port !== 24'h0) begin n_errors++; $display("FAIL reset_out_port got %h expected %h", out_port, 24'h0); end
    n_checks++; if (bcd_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b expected 0", bcd_busy); end
    bus.addr = 32'h98; #1;
    n_checks++; if (bus.rdata !== 32'd0) begin n_errors++; $display("FAIL reset_mode_rd got %h expected 0", bus.rdata); end
    bus.addr = 32'h9C; #1;
    n_checks++; if (bus.rdata !== 32'd0) begin n_errors++; $display("FAIL reset_status_rd got %h expected 0", bus.rdata); end
    clrn = 1'b1;
    @(negedge io_clk);
  endtask

  task automatic test_port_write();
    wr(32'h80, 32'hA5, 1'b1);
    wr(32'h94, 32'h7, 1'b1);
    n_checks++; if (port_of(0) !== 4'd5) begin n_errors++; $display("FAIL port0_write got %0d expected 5", port_of(0)); end
    n_checks++; if (port_of(5) !== 4'd7) begin n_errors++; $display("FAIL port5_write got %0d expected 7", port_of(5)); end
    bus.addr = 32'h80; #1;
    n_checks++; if (bus.rdata !== 32'd5) begin n_errors++; $display("FAIL port0_rd got %h expected 5", bus.rdata); end
    wr(32'h84, 32'h3, 1'b0);
    n_checks++; if (port_of(1) !== 4'd0) begin n_errors++; $display("FAIL port1_no_we got %0d expected 0", port_of(1)); end
    n_checks++; if (out_port !== exp_out()) begin n_errors++; $display("FAIL write_model got %h expected %h", out_port, exp_out()); end
  endtask

  task automatic test_bcd_255();
    int busy_cnt;
    int ed[3];
    ed = '{5, 5, 2};
    busy_cnt = 0;
    wr(32'h98, 32'h07, 1'b1);
    in_port = 8'd255;
    for (int k = 1; k <= 14; k++) begin
      @(negedge io_clk);
      if (bcd_busy) busy_cnt++;
      n_checks++; if (out_port !== exp_out() || bcd_busy !== (m_rem != 0)) begin
        n_errors++; $display("FAIL bcd255_model edge %0d got %h/%b expected %h/%b", k, out_port, bcd_busy, exp_out(), (m_rem != 0)); end
      if (k == 11) for (int i = 0; i < 3; i++) begin
        n_checks++; if (port_of(i) !== 4'd0) begin n_errors++; $display("FAIL bcd255_early port%0d got %0d expected 0", i, port_of(i)); end
      end
      if (k == 12) for (int i = 0; i < 3; i++) begin
        n_checks++; if (port_of(i) !== 4'(ed[i])) begin n_errors++; $display("FAIL bcd255_digit port%0d got %0d expected %0d", i, port_of(i), ed[i]); end
      end
    end
    n_checks++; if (busy_cnt != 9) begin n_errors++; $display("FAIL bcd255_busy_len got %0d expected 9", busy_cnt); end
    n_checks++; if (port_of(5) !== 4'd7) begin n_errors++; $display("FAIL bcd255_port5 got %0d expected 7", port_of(5)); end
    bus.addr = 32'h9C; #1;
    n_checks++; if (bus.rdata[15:8] !== 8'd1) begin n_errors++; $display("FAIL bcd255_count got %0d expected 1", bus.rdata[15:8]); end
  endtask

  task automatic test_restart();
    int e1[3], e2[3];
    e1 = '{7, 3, 0};
    e2 = '{2, 4, 1};
    in_port = 8'd37;
    for (int k = 1; k <= 24; k++) begin
      @(negedge io_clk);
      if (k == 6) in_port = 8'd142;
      n_checks++; if (out_port !== exp_out() || bcd_busy !== (m_rem != 0)) begin
        n_errors++; $display("FAIL restart_model edge %0d got %h/%b expected %h/%b", k, out_port, bcd_busy, exp_out(), (m_rem != 0)); end
      if (k == 12 || k == 21) for (int i = 0; i < 3; i++) begin
        n_checks++; if (port_of(i) !== 4'(e1[i])) begin n_errors++; $display("FAIL restart_first port%0d edge %0d got %0d expected %0d", i, k, port_of(i), e1[i]); end
      end
      if (k == 22) for (int i = 0; i < 3; i++) begin
        n_checks++; if (port_of(i) !== 4'(e2[i])) begin n_errors++; $display("FAIL restart_second port%0d got %0d expected %0d", i, port_of(i), e2[i]); end
      end
    end
    bus.addr = 32'h9C; #1;
    n_checks++; if (bus.rdata[15:8] !== 8'd3) begin n_errors++; $display("FAIL restart_count got %0d expected 3", bus.rdata[15:8]); end
    in_port = 8'd100;
    repeat (14) @(negedge io_clk);
    n_checks++; if (out_port[11:0] !== 12'h100) begin n_errors++; $display("FAIL bcd100 got %h expected 100", out_port[11:0]); end
    in_port = 8'd0;
    repeat (14) @(negedge io_clk);
    n_checks++; if (out_port[11:0] !== 12'h000) begin n_errors++; $display("FAIL bcd0 got %h expected 000", out_port[11:0]); end
  endtask

  task automatic test_mode_high_ports();
    wr(32'h90, 32'h9, 1'b1);
    wr(32'h98, 32'h17, 1'b1);
    n_checks++; if (port_of(4) !== 4'd0) begin n_errors++; $display("FAIL mode_port4 got %0d expected 0", port_of(4)); end
    n_checks++; if (out_port !== exp_out()) begin n_errors++; $display("FAIL mode_model got %h expected %h", out_port, exp_out()); end
    wr(32'h98, 32'h0, 1'b1);
    n_checks++; if (port_of(0) !== 4'd5) begin n_errors++; $display("FAIL mode_clear_port0 got %0d expected 5", port_of(0)); end
    n_checks++; if (port_of(4) !== 4'd9) begin n_errors++; $display("FAIL mode_clear_port4 got %0d expected 9", port_of(4)); end
    n_checks++; if (out_port !== 24'h790005) begin n_errors++; $display("FAIL mode_clear_all got %h expected 790005", out_port); end
  endtask

  task automatic test_reset_mid_shift();
    wr(32'h98, 32'h07, 1'b1);
    in_port = 8'd200;
    repeat (6) @(negedge io_clk);
    n_checks++; if (bcd_busy !== 1'b1) begin n_errors++; $display("FAIL midshift_busy got %b expected 1", bcd_busy); end
    #2; clrn = 1'b0; in_port = 8'd0; bus.addr = 32'h80; #1;
    n_checks++; if (out_port !== 24'h0) begin n_errors++; $display("FAIL async_rst_out got %h expected 0", out_port); end
    n_checks++; if (bcd_busy !== 1'b0) begin n_errors++; $display("FAIL async_rst_busy got %b expected 0", bcd_busy); end
    n_checks++; if (bus.rdata !== 32'd0) begin n_errors++; $display("FAIL async_rst_rd got %h expected 0", bus.rdata); end
    @(negedge io_clk);
    clrn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge io_clk);
      n_checks++; if (bcd_busy !== 1'b0) begin n_errors++; $display("FAIL post_rst_idle cycle %0d got %b expected 0", k, bcd_busy); end
    end
    bus.addr = 32'h9C; #1;
    n_checks++; if (bus.rdata !== 32'd0) begin n_errors++; $display("FAIL post_rst_status got %h expected 0", bus.rdata); end
  endtask

  task automatic test_random();
    logic [31:0] a, r;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) in_port = IW'($urandom);
      r = $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = (r & 32'hFFFF_FF00) | (32'h80 + 32'($urandom_range(0, 9)) * 4 + 32'($urandom_range(0, 3)));
      bus.addr = a;
      bus.datain = $urandom;
      bus.write_io_enable = ($urandom_range(0, 1) == 1);
      #1;
      n_checks++; if (bus.rdata !== exp_rdata(a)) begin n_errors++; $display("FAIL rand_rdata addr %h got %h expected %h", a, bus.rdata, exp_rdata(a)); end
      @(negedge io_clk);
      n_checks++; if (out_port !== exp_out() || bcd_busy !== (m_rem != 0)) begin
        n_errors++; $display("FAIL rand_out cycle %0d got %h/%b expected %h/%b", k, out_port, bcd_busy, exp_out(), (m_rem != 0)); end
    end
    bus.write_io_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_port_write();
    test_bcd_255();
    test_restart();
    test_mode_high_ports();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
